// File: rtl/data_memory_responder.sv
// Load/store responder: byte-addressable little-endian word memory with WAIT_CYCLES wait states
// and a one-cycle response pulse. Define DMEM_ALIGN_CHECK_EN to reject misaligned and illegal-size requests.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic          w_enter_resp;

  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_unsigned;

  logic          w_a_write;
  logic [31:0]   w_a_addr;
  logic [31:0]   w_a_wdata;
  logic [1:0]    w_a_size;
  logic          w_a_unsigned;

  logic [1:0]    w_size_eff;
  logic [1:0]    w_lo;
  logic          w_oor;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [31:0]   w_shift;
  logic [31:0]   w_rdata;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;

  assign req_ready  = !rst && (r_state != ST_WAIT);
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // State and wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; w_enter_resp marks the edge that performs the access
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CW'(WAIT_CYCLES - 1);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture on acceptance
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write    <= req_write;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
    end
  end

  // With zero wait states the access happens on the acceptance edge, so use the live request
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      w_a_write    = req_write;
      w_a_addr     = req_addr;
      w_a_wdata    = req_wdata;
      w_a_size     = req_size;
      w_a_unsigned = req_unsigned;
    end else begin
      w_a_write    = r_write;
      w_a_addr     = r_addr;
      w_a_wdata    = r_wdata;
      w_a_size     = r_size;
      w_a_unsigned = r_unsigned;
    end
  end

  assign w_oor = ({2'b00, w_a_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx = w_a_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    w_size_eff = w_a_size;
    w_lo       = w_a_addr[1:0];
    w_err      = w_oor
              || (w_a_size == 2'b11)
              || ((w_a_size == 2'b01) && w_a_addr[0])
              || ((w_a_size == 2'b10) && (w_a_addr[1:0] != 2'b00));
  end
`else
  // Force-align instead of rejecting; size 11 behaves as word
  always_comb begin
    w_size_eff = (w_a_size == 2'b11) ? 2'b10 : w_a_size;
    case (w_size_eff)
      2'b00:   w_lo = w_a_addr[1:0];
      2'b01:   w_lo = {w_a_addr[1], 1'b0};
      default: w_lo = 2'b00;
    endcase
    w_err = w_oor;
  end
`endif

  // Byte-lane enables and replicated store data
  always_comb begin
    case (w_size_eff)
      2'b00: begin
        w_be     = 4'b0001 << w_lo;
        w_wlanes = {4{w_a_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_a_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = w_a_wdata;
      end
    endcase
  end

  assign w_rword = r_mem[w_idx];
  assign w_shift = w_rword >> {w_lo, 3'b000};

  // Load data extraction and extension
  always_comb begin
    case (w_size_eff)
      2'b00:   w_rdata = w_a_unsigned ? {24'd0, w_shift[7:0]}
                                      : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_rdata = w_a_unsigned ? {16'd0, w_shift[15:0]}
                                      : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_rdata = w_rword;
    endcase
    if (w_err || w_a_write) begin
      w_rdata = 32'd0;
    end
  end

  // Memory write; reset blocks a pending store from committing
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_a_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
        end
      end
    end
  end

  // Response registers hold between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_enter_resp;
      if (w_enter_resp) begin
        r_resp_rdata <= w_rdata;
        r_resp_err   <= w_err;
      end
    end
  end

endmodule
